mp_sub_ctrl: RTL and testbench
==============================

# mp_sub_ctrl

Multi-precision subtract sequencer for the m_cpu datapath. Accepts two WORDS×N-bit operands and a borrow-in, then feeds them one N-bit word per cycle, LSW first, through a single shared `sub` ripple subtractor instance. The borrow is chained between words in a register. Used for wide (e.g. 64-bit) SUB/SBC and compare operations without widening the adder/subtractor datapath. Valid/ready handshakes on both the operand and result sides.

## Interface
- `N`, 16: word width of the shared subtractor.
- `WORDS`, 4: number of words per operation; must be ≥ 2.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start_valid` input 1: operands present on `rs1_reg`/`rs2_reg`/`bin`.
- `start_ready` output 1: controller can accept an operation.
- `rs1_reg` input N*WORDS: minuend.
- `rs2_reg` input N*WORDS: subtrahend.
- `bin` input 1: borrow-in to the LSW.
- `res_valid` output 1: result held stable on `sub_rd`/`bo`/`zero`.
- `res_ready` input 1: consumer accepts the result.
- `sub_rd` output N*WORDS: difference, rs1_reg − rs2_reg − bin, modulo 2^(N*WORDS).
- `bo` output 1: borrow-out of the MSW (1 iff rs1_reg < rs2_reg + bin, unsigned).
- `zero` output 1: `sub_rd` == 0.
- `busy` output 1: state ≠ IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - `start_ready`=1.
  - On `start_valid`&&`start_ready`: latch `rs1_reg`, `rs2_reg` into operand registers; borrow register ← `bin`; `idx` ← 0; clear the `zero` accumulator to 1; go to RUN.
- RUN, each cycle:
  - Subtractor inputs are word `idx` of the latched operands plus the borrow register.
  - Write the subtractor difference into result slice `idx`.
  - Borrow register ← subtractor `bo`.
  - `zero` accumulator &= (difference == 0).
  - If `idx`==WORDS−1, go to DONE; otherwise `idx`++.
- DONE:
  - `res_valid`=1.
  - `sub_rd`, `bo` (the borrow register) and `zero` are held stable.
  - On `res_ready`, go to IDLE.
- `start_ready`=0 in RUN and DONE. Input changes there are ignored; operands are latched only on acceptance.
- `sub_rd` keeps its last value after returning to IDLE. It is guaranteed valid only while `res_valid`=1.
- Width rules:
  - `idx` is $clog2(WORDS) bits and never wraps past WORDS−1.
  - The result is WORDS*N bits with no sign extension.
  - `bo` is the unsigned borrow.

## Timing
- Reset values: `start_ready`=0 during the cycle `rst` is high and 1 from the first cycle after; `res_valid`=0, `busy`=0, `sub_rd`=0, `bo`=0, `zero`=0; state=IDLE, `idx`=0, borrow register=0.
- Acceptance edge is E. RUN occupies cycles E+1 … E+WORDS. `res_valid` rises after edge E+WORDS. Latency is WORDS cycles from acceptance to `res_valid`.
- Throughput: one operation per WORDS+2 cycles best case (IDLE cycle, WORDS RUN cycles, at least one DONE cycle).
- `res_valid` stays high indefinitely until `res_ready` is sampled high. `res_ready` outside DONE is ignored.
- `start_valid` and `res_ready` both high in DONE: only the result handshake completes. The new operation is accepted at the earliest in the following IDLE cycle.
- `rst` high in any state, including mid-RUN: next state is IDLE with all reset values. The partial result is discarded and `res_valid` never pulses.
- The subtractor path is purely combinational inside one RUN cycle. No multicycle path.

## Structure
- Package `mp_sub_pkg`:
  - `mp_sub_state_t` enum {IDLE, RUN, DONE}.
  - Localparam defaults `MP_WORD_W`=16 and `MP_WORDS`=4.
- One sub-module: exactly one instance of the existing `sub` subtractor with `N` passed through. Its `bin` port is the borrow register and its `bo` port feeds the register's D input.
- Everything else lives in one always_ff block plus combinational next-state logic: operand, result and borrow registers, `idx` counter, FSM.

## Test plan
- N=16, WORDS=4, bin=0; rs1_reg=0x0000_0000_0001_0000, rs2_reg=0x1 → `sub_rd`=0x0000_0000_0000_FFFF, `bo`=0, `zero`=0. `res_valid` rises exactly 4 cycles after acceptance.
- rs1_reg=0, rs2_reg=1, bin=0 → `sub_rd`=0xFFFF_FFFF_FFFF_FFFF, `bo`=1, `zero`=0. Borrow propagates through all 4 words.
- rs1_reg=rs2_reg=0x1234_5678_9ABC_DEF0, bin=0 → `sub_rd`=0, `bo`=0, `zero`=1. Repeat with bin=1 → all ones, `bo`=1, `zero`=0.
- Hold `res_ready`=0 for 10 cycles with `start_valid`=1 and changing operands throughout → outputs stay stable and `start_ready` stays 0. Release `res_ready` → exactly one IDLE cycle, then the next operation is accepted.
- Assert `rst` for 1 cycle at RUN `idx`=2 → next cycle state=IDLE, `res_valid`=0, `sub_rd`=0, `bo`=0. A following operation 5−2 with bin=1 gives 2.
- Back-to-back: 50 random operations with random `start_valid`/`res_ready` gaps. Scoreboard checks each `sub_rd`/`bo`/`zero` against a 64-bit golden model, with no lost or duplicated results.

Source files
------------

// File: rtl/mp_sub_pkg.sv
// Shared types and default sizing for the multi-precision subtract sequencer.
package mp_sub_pkg;

    localparam int MP_WORD_W = 16;
    localparam int MP_WORDS  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mp_sub_state_t;

endpackage

// File: rtl/sub.sv
// Single-word ripple subtractor with borrow-in/borrow-out: d = a - b - bin.
module sub #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic [N-1:0] d,
    output logic         bo
);

    logic [N:0] diff;

    // The extra top bit goes high exactly when a < b + bin, i.e. the unsigned borrow.
    assign diff = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bin};
    assign d    = diff[N-1:0];
    assign bo   = diff[N];

endmodule

// File: rtl/mp_sub_ctrl.sv
// Multi-precision subtract sequencer: streams WORDS words, LSW first, through
// one shared subtractor and chains the borrow between words in a register.
module mp_sub_ctrl
    import mp_sub_pkg::*;
#(
    parameter int N     = MP_WORD_W,
    parameter int WORDS = MP_WORDS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic [N*WORDS-1:0] rs1_reg,
    input  logic [N*WORDS-1:0] rs2_reg,
    input  logic               bin,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [N*WORDS-1:0] sub_rd,
    output logic               bo,
    output logic               zero,
    output logic               busy
);

    localparam int IW = $clog2(WORDS);

    mp_sub_state_t    state;
    mp_sub_state_t    state_next;
    logic [IW-1:0]    idx;
    logic [N*WORDS-1:0] rs1_q;
    logic [N*WORDS-1:0] rs2_q;
    logic [N*WORDS-1:0] res_q;
    logic             borrow_q;
    logic             zero_q;
    logic [N-1:0]     diff;
    logic             diff_bo;

    sub #(.N(N)) u_sub (
        .a   (rs1_q[N*int'(idx) +: N]),
        .b   (rs2_q[N*int'(idx) +: N]),
        .bin (borrow_q),
        .d   (diff),
        .bo  (diff_bo)
    );

    // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_valid) state_next = RUN;
            RUN:     if (idx == IW'(WORDS - 1)) state_next = DONE;
            DONE:    if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: the operand registers carry no reset; they are only read after being loaded on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        rs1_q    <= rs1_reg;
                        rs2_q    <= rs2_reg;
                        borrow_q <= bin;
                        idx      <= '0;
                        zero_q   <= 1'b1;
                    end
                end
                RUN: begin
                    res_q[N*int'(idx) +: N] <= diff;
                    borrow_q <= diff_bo;
                    zero_q   <= zero_q & (diff == '0);
                    if (idx != IW'(WORDS - 1)) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign start_ready = (state == IDLE) && !rst;
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);
    assign sub_rd      = res_q;
    assign bo          = borrow_q;
    assign zero        = zero_q;

endmodule

// File: tb/tb_mp_sub_ctrl.sv
// Directed and randomised checks of mp_sub_ctrl (N=16, WORDS=4) against a 64-bit subtract model.
module tb_mp_sub_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [63:0] rs1_reg;
    logic [63:0] rs2_reg;
    logic        bin;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] sub_rd;
    logic        bo;
    logic        zero;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mp_sub_ctrl #(.N(16), .WORDS(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .rs1_reg     (rs1_reg),
        .rs2_reg     (rs2_reg),
        .bin         (bin),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .sub_rd      (sub_rd),
        .bo          (bo),
        .zero        (zero),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation and hold start_valid until the acceptance edge has passed.
    task automatic accept(input logic [63:0] a, input logic [63:0] b, input logic bi);
        int guard;
        guard       = 0;
        rs1_reg     = a;
        rs2_reg     = b;
        bin         = bi;
        start_valid = 1'b1;
        while (!start_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (guard >= 50) check("accept_timeout", 64'(guard), 64'd0);
        tick();
        start_valid = 1'b0;
        rs1_reg     = {$urandom, $urandom};
        rs2_reg     = {$urandom, $urandom};
        bin         = 1'($urandom);
    endtask

    task automatic wait_result(output int cycles);
        cycles = 0;
        while (!res_valid && cycles < 32) begin
            tick();
            cycles++;
        end
    endtask

    task automatic release_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("res_valid_drop", 64'(res_valid), 64'd0);
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic bi,
                          input logic [63:0] exp_d, input logic exp_bo, input logic exp_z);
        int lat;
        accept(a, b, bi);
        wait_result(lat);
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_sub_rd"}, sub_rd, exp_d);
        check({tag, "_bo"}, 64'(bo), 64'(exp_bo));
        check({tag, "_zero"}, 64'(zero), 64'(exp_z));
        release_result();
    endtask

    initial begin
        int          lat;
        logic [63:0] a;
        logic [63:0] b;
        logic        bi;
        logic [64:0] gold;

        rst         = 1'b1;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        rs1_reg     = '0;
        rs2_reg     = '0;
        bin         = 1'b0;

        // Reset state
        tick();
        check("rst_start_ready", 64'(start_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_sub_rd", sub_rd, 64'd0);
        check("rst_bo", 64'(bo), 64'd0);
        check("rst_zero", 64'(zero), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_start_ready", 64'(start_ready), 64'd1);

        // Directed vectors
        run_op("word_borrow", 64'h0000_0000_0001_0000, 64'h1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0);
        run_op("full_borrow", 64'h0, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
        run_op("equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h0, 1'b0, 1'b1);
        run_op("equal_bin", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);

        // Stall in DONE with new operands being offered throughout
        accept(64'd10, 64'd3, 1'b0);
        wait_result(lat);
        check("stall_latency", 64'(lat), 64'd4);
        start_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rs1_reg = 64'(100 + i);
            rs2_reg = 64'd1;
            tick();
            check("stall_sub_rd", sub_rd, 64'd7);
            check("stall_res_valid", 64'(res_valid), 64'd1);
            check("stall_start_ready", 64'(start_ready), 64'd0);
        end
        rs1_reg   = 64'd100;
        rs2_reg   = 64'd1;
        bin       = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("release_idle_busy", 64'(busy), 64'd0);
        check("release_idle_ready", 64'(start_ready), 64'd1);
        tick();
        start_valid = 1'b0;
        check("next_accepted_busy", 64'(busy), 64'd1);
        wait_result(lat);
        check("next_latency", 64'(lat), 64'd4);
        check("next_sub_rd", sub_rd, 64'd99);
        release_result();

        // Reset in the middle of RUN, while idx is 2
        accept(64'h0, 64'h1, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_res_valid", 64'(res_valid), 64'd0);
        check("midrst_sub_rd", sub_rd, 64'd0);
        check("midrst_bo", 64'(bo), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_pulse", 64'(res_valid), 64'd0);
        end
        run_op("after_rst", 64'd5, 64'd2, 1'b1, 64'd2, 1'b0, 1'b0);

        // Random operations with random gaps on both handshakes
        for (int n = 0; n < 50; n++) begin
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 7) == 0) ? a : {$urandom, $urandom};
            bi = 1'($urandom);
            gold = {1'b0, a} - {1'b0, b} - 65'(bi);
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            accept(a, b, bi);
            wait_result(lat);
            check("rand_latency", 64'(lat), 64'd4);
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            check("rand_sub_rd", sub_rd, gold[63:0]);
            check("rand_bo", 64'(bo), 64'(gold[64]));
            check("rand_zero", 64'(zero), 64'(gold[63:0] == 64'd0));
            release_result();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
